timer0_wave_gen: RTL and testbench

- 8-bit Timer0 counter and compare unit for the ATmega32A emulator timer0_8bit block.
- Sits directly upstream of the OC0 output set/reset latch.
- Counts prescaler ticks and evaluates OCR0 compare match in the four WGM0 modes.
- Drives the latch's s/r inputs so that latch Q is the OC0 pin waveform; also raises OCF0/TOV0 event pulses for the interrupt flag logic.

---
 rtl/timer0_wave_gen.sv | 204 ++++++++++++++++++++
 tb/tb_timer0_wave_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer0_wave_gen.sv
// rtl/timer0_wave_gen.sv - Timer0 8-bit counter, OCR0 compare and OC0 latch s/r driver (optional force compare: TIMER0_FOC_EN)
module timer0_wave_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [1:0]       wgm,
   input  logic [1:0]       com,
   input  logic [WIDTH-1:0] ocr_wdata,
   input  logic             ocr_wr,
   input  logic [WIDTH-1:0] tcnt_wdata,
   input  logic             tcnt_wr,
   input  logic             foc,
   input  logic             oc_q,
   output logic [WIDTH-1:0] tcnt,
   output logic [WIDTH-1:0] ocr,
   output logic             ocf,
   output logic             tov,
   output logic             latch_s,
   output logic             latch_r
);

   localparam logic [1:0] WGM_NORMAL = 2'd0;
   localparam logic [1:0] WGM_PC     = 2'd1;
   localparam logic [1:0] WGM_CTC    = 2'd2;
   localparam logic [1:0] WGM_FAST   = 2'd3;

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] tcnt_q, tcnt_d;
   logic [WIDTH-1:0] ocr_q, ocr_d;
   logic [WIDTH-1:0] ocr_buf_q, ocr_buf_d;
   logic [1:0]       wgm_q;
   logic             dir_down_q, dir_down_d;
   logic             blk_q, blk_d;
   logic             ocf_q, tov_q, s_q, r_q;
   logic             tov_d, act_set, act_clr;

   // a tick that is not overridden by a same-cycle TCNT0 write
   logic step;
   logic at_max, at_zero, cmp_eq, match, non_pwm;

   assign step    = tick & ~tcnt_wr;
   assign at_max  = (tcnt_q == CNT_MAX);
   assign at_zero = (tcnt_q == '0);
   assign cmp_eq  = (tcnt_q == ocr_q);
   assign match   = step & ~blk_q & cmp_eq;
   assign non_pwm = ~wgm[0];

   // non-PWM compare output action, returned as {set, clr}
   function automatic logic [1:0] np_action(input logic [1:0] c, input logic q);
      logic [1:0] a;
      a = 2'b00;
      case (c)
         2'b01:   a = q ? 2'b01 : 2'b10;
         2'b10:   a = 2'b01;
         2'b11:   a = 2'b10;
         default: a = 2'b00;
      endcase
      return a;
   endfunction

   // counter step, direction and overflow
   always_comb begin
      tcnt_d     = tcnt_q;
      dir_down_d = dir_down_q;
      tov_d      = 1'b0;
      if (tcnt_wr) begin
         tcnt_d = tcnt_wdata;
      end else if (tick) begin
         case (wgm)
            WGM_CTC: begin
               tcnt_d     = cmp_eq ? '0 : tcnt_q + 1'b1;
               tov_d      = at_max;
               dir_down_d = 1'b0;
            end
            WGM_PC: begin
               if (!dir_down_q) begin
                  if (at_max) begin
                     dir_down_d = 1'b1;
                     tcnt_d     = tcnt_q - 1'b1;
                  end else begin
                     tcnt_d = tcnt_q + 1'b1;
                  end
               end else begin
                  if (at_zero) begin
                     dir_down_d = 1'b0;
                     tcnt_d     = tcnt_q + 1'b1;
                  end else begin
                     tcnt_d = tcnt_q - 1'b1;
                     tov_d  = (tcnt_q == CNT_ONE);
                  end
               end
            end
            default: begin
               tcnt_d     = tcnt_q + 1'b1;
               tov_d      = at_max;
               dir_down_d = 1'b0;
            end
         endcase
      end
   end

   // OCR0 buffering: immediate in non-PWM modes, double-buffered in PWM modes
   always_comb begin
      ocr_d     = ocr_q;
      ocr_buf_d = ocr_buf_q;
      if (ocr_wr) begin
         ocr_buf_d = ocr_wdata;
      end
      if (non_pwm) begin
         if (ocr_wr) begin
            ocr_d = ocr_wdata;
         end else if (wgm != wgm_q) begin
            ocr_d = ocr_buf_q;
         end
      end else if (step && at_max) begin
         // fast PWM wraps and phase-correct turns around at MAX
         ocr_d = ocr_buf_q;
      end
   end

   // a TCNT0 write suppresses the compare on the following tick only
   always_comb begin
      blk_d = blk_q;
      if (tcnt_wr) begin
         blk_d = 1'b1;
      end else if (tick) begin
         blk_d = 1'b0;
      end
   end

   // compare output action towards the OC0 latch
   always_comb begin
      act_set = 1'b0;
      act_clr = 1'b0;
      if (match) begin
         case (wgm)
            WGM_FAST: begin
               act_clr = (com == 2'b10);
               act_set = (com == 2'b11);
            end
            WGM_PC: begin
               // the direction held at the compare tick is the incoming one
               act_clr = (com == 2'b10 && !dir_down_q) || (com == 2'b11 && dir_down_q);
               act_set = (com == 2'b10 && dir_down_q) || (com == 2'b11 && !dir_down_q);
            end
            default: begin
               {act_set, act_clr} = np_action(com, oc_q);
            end
         endcase
      end else if (wgm == WGM_FAST && step && at_max) begin
         act_set = (com == 2'b10);
         act_clr = (com == 2'b11);
      end
`ifdef TIMER0_FOC_EN
      else if (foc && non_pwm) begin
         {act_set, act_clr} = np_action(com, oc_q);
      end
`endif
   end

`ifndef TIMER0_FOC_EN
   logic unused_foc;
   assign unused_foc = foc;
`endif

   // state registers and registered one-clk event outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt_q     <= '0;
         ocr_q      <= '0;
         ocr_buf_q  <= '0;
         wgm_q      <= WGM_NORMAL;
         dir_down_q <= 1'b0;
         blk_q      <= 1'b0;
         ocf_q      <= 1'b0;
         tov_q      <= 1'b0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
      end else begin
         tcnt_q     <= tcnt_d;
         ocr_q      <= ocr_d;
         ocr_buf_q  <= ocr_buf_d;
         wgm_q      <= wgm;
         dir_down_q <= dir_down_d;
         blk_q      <= blk_d;
         ocf_q      <= match;
         tov_q      <= tov_d;
         s_q        <= act_set;
         r_q        <= act_set | act_clr;
      end
   end

   assign tcnt    = tcnt_q;
   assign ocr     = ocr_q;
   assign ocf     = ocf_q;
   assign tov     = tov_q;
   assign latch_s = s_q;
   assign latch_r = r_q;

endmodule

// File: tb/tb_timer0_wave_gen.sv
// tb/tb_timer0_wave_gen.sv - directed self-checking bench for timer0_wave_gen
module tb_timer0_wave_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic [1:0] wgm;
   logic [1:0] com;
   logic [7:0] ocr_wdata;
   logic       ocr_wr;
   logic [7:0] tcnt_wdata;
   logic       tcnt_wr;
   logic       foc;
   logic       oc_q;
   logic [7:0] tcnt;
   logic [7:0] ocr;
   logic       ocf;
   logic       tov;
   logic       latch_s;
   logic       latch_r;

   int checks = 0;
   int failures = 0;
   int cnt;
   int high;

   timer0_wave_gen #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .wgm        (wgm),
      .com        (com),
      .ocr_wdata  (ocr_wdata),
      .ocr_wr     (ocr_wr),
      .tcnt_wdata (tcnt_wdata),
      .tcnt_wr    (tcnt_wr),
      .foc        (foc),
      .oc_q       (oc_q),
      .tcnt       (tcnt),
      .ocr        (ocr),
      .ocf        (ocf),
      .tov        (tov),
      .latch_s    (latch_s),
      .latch_r    (latch_r)
   );

   always #5 clk = ~clk;

   // OC0 set/reset latch model feeding Q back to the DUT
   always @(posedge clk or posedge reset) begin
      if (reset) oc_q <= 1'b0;
      else if (latch_r) oc_q <= latch_s;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick = 1'b0; ocr_wr = 1'b0; tcnt_wr = 1'b0; foc = 1'b0;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; wgm = 2'd0; com = 2'd0;
      ocr_wdata = 8'd0; ocr_wr = 1'b0; tcnt_wdata = 8'd0; tcnt_wr = 1'b0; foc = 1'b0;
      cyc();
      check("rst_tcnt", tcnt, 0);
      check("rst_ocr", ocr, 0);
      check("rst_ocf", ocf, 0);
      check("rst_tov", tov, 0);
      check("rst_s", latch_s, 0);
      check("rst_r", latch_r, 0);
      reset = 1'b0;

      // normal mode: full count with a single wrap
      tick = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 256; k++) begin
         cyc();
         check("norm_tcnt", tcnt, k % 256);
         if (tov) cnt++;
         if (k == 256) check("norm_tov_wrap", tov, 1);
      end
      check("norm_tov_count", cnt, 1);
      tick = 1'b0;

      // CTC toggle with OCR0 = 9
      pulse_reset();
      wgm = 2'd2; com = 2'd1; ocr_wdata = 8'd9; ocr_wr = 1'b1;
      cyc();
      ocr_wr = 1'b0;
      check("ctc_ocr", ocr, 9);
      tick = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         check("ctc_tcnt", tcnt, k % 10);
         if (ocf) cnt++;
         if (k == 10) begin check("ctc_s10", latch_s, 1); check("ctc_r10", latch_r, 1); end
         if (k == 20) begin check("ctc_s20", latch_s, 0); check("ctc_r20", latch_r, 1); end
         if (k == 30) begin check("ctc_s30", latch_s, 1); check("ctc_r30", latch_r, 1); end
         if (k == 15) check("ctc_oc15", oc_q, 1);
         if (k == 25) check("ctc_oc25", oc_q, 0);
         if (k == 35) check("ctc_oc35", oc_q, 1);
      end
      check("ctc_ocf_count", cnt, 4);
      // asynchronous reset while a latch action is pending
      reset = 1'b1;
      #1;
      check("arst_s", latch_s, 0);
      check("arst_r", latch_r, 0);
      check("arst_ocf", ocf, 0);
      check("arst_tcnt", tcnt, 0);
      tick = 1'b0;
      cyc();
      reset = 1'b0;

      // fast PWM, com 10, OCR0 64, then buffered write of 200
      pulse_reset();
      wgm = 2'd0; ocr_wdata = 8'd64; ocr_wr = 1'b1;
      cyc();
      ocr_wr = 1'b0; wgm = 2'd3; com = 2'd2; tick = 1'b1;
      high = 0;
      for (int k = 1; k <= 768; k++) begin
         cyc();
         if (k >= 257 && k <= 512 && oc_q) high++;
         if (k == 65) begin
            check("fast_clr_s", latch_s, 0); check("fast_clr_r", latch_r, 1); check("fast_ocf", ocf, 1);
         end
         if (k == 100) begin check("fast_idle_s", latch_s, 0); check("fast_idle_r", latch_r, 0); end
         if (k == 256) begin
            check("fast_set_s", latch_s, 1); check("fast_set_r", latch_r, 1);
            check("fast_tov", tov, 1); check("fast_wrap", tcnt, 0);
         end
         if (k == 612) begin ocr_wdata = 8'd200; ocr_wr = 1'b1; end
         if (k == 613) ocr_wr = 1'b0;
         if (k == 700) check("fast_ocr_hold", ocr, 64);
         if (k == 767) check("fast_ocr_prewrap", ocr, 64);
         if (k == 768) begin check("fast_ocr_load", ocr, 200); check("fast_wrap2", tcnt, 0); end
      end
      check("fast_duty", high, 65);
      tick = 1'b0;

      // phase-correct, com 10, OCR0 128
      pulse_reset();
      wgm = 2'd0; com = 2'd0; ocr_wdata = 8'd128; ocr_wr = 1'b1;
      cyc();
      ocr_wr = 1'b0; wgm = 2'd1; com = 2'd2; tick = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 1020; k++) begin
         cyc();
         if (tov) cnt++;
         if (k == 129) begin
            check("pc_up_s", latch_s, 0); check("pc_up_r", latch_r, 1); check("pc_up_ocf", ocf, 1);
         end
         if (k == 255) check("pc_max", tcnt, 255);
         if (k == 256) check("pc_turn", tcnt, 254);
         if (k == 383) begin check("pc_dn_s", latch_s, 1); check("pc_dn_r", latch_r, 1); end
         if (k == 400) check("pc_oc", oc_q, 1);
         if (k == 510) begin check("pc_bottom", tcnt, 0); check("pc_tov", tov, 1); end
         if (k == 511) check("pc_restart", tcnt, 1);
         if (k == 1020) check("pc_period2", tcnt, 0);
      end
      check("pc_tov_count", cnt, 2);
      tick = 1'b0;

      // mode change from PWM copies the buffer into OCR0
      pulse_reset();
      wgm = 2'd3; ocr_wdata = 8'd77; ocr_wr = 1'b1;
      cyc();
      ocr_wr = 1'b0;
      check("mode_ocr_buffered", ocr, 0);
      wgm = 2'd0;
      cyc();
      check("mode_ocr_copy", ocr, 77);

      // TCNT0 write blocks the next compare only
      pulse_reset();
      wgm = 2'd0; com = 2'd3; ocr_wdata = 8'd50; ocr_wr = 1'b1;
      cyc();
      ocr_wr = 1'b0; tcnt_wdata = 8'd50; tcnt_wr = 1'b1;
      cyc();
      tcnt_wr = 1'b0;
      check("blk_load", tcnt, 50);
      tick = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 257; k++) begin
         cyc();
         if (ocf) cnt++;
         if (k == 1) begin
            check("blk_ocf", ocf, 0); check("blk_r", latch_r, 0); check("blk_tcnt", tcnt, 51);
         end
         if (k == 257) begin
            check("blk_next_ocf", ocf, 1); check("blk_next_s", latch_s, 1); check("blk_next_r", latch_r, 1);
         end
      end
      check("blk_ocf_count", cnt, 1);
      tick = 1'b0;

      // TCNT0 write wins over a same-cycle tick at MAX
      tcnt_wdata = 8'd255; tcnt_wr = 1'b1;
      cyc();
      tcnt_wdata = 8'd7; tick = 1'b1;
      cyc();
      tcnt_wr = 1'b0; tick = 1'b0;
      check("wr_tick_tcnt", tcnt, 7);
      check("wr_tick_tov", tov, 0);

      // force output compare, normal mode, com 11
      foc = 1'b1;
      cyc();
      foc = 1'b0;
`ifdef TIMER0_FOC_EN
      check("foc_s", latch_s, 1);
      check("foc_r", latch_r, 1);
`else
      check("foc_s", latch_s, 0);
      check("foc_r", latch_r, 0);
`endif
      check("foc_ocf", ocf, 0);
      check("foc_tcnt", tcnt, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
